// File: rtl/shift_ex_pkg.sv
// rtl/shift_ex_pkg.sv - shared widths, opcodes and stage-A payload for the shift EX slot
package shift_ex_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_SHAMT_W = 4;
    localparam int DEF_REG_W   = 4;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [1:0]             opcode;
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_SHAMT_W-1:0] imm;
        logic [DEF_REG_W-1:0]   rd;
    } stage_a_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational log shifter for SLL/SRA/ROR
module shift_core
    import shift_ex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [1:0]         opcode,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] lvl [SHAMT_W+1];

    assign lvl[0] = data;

    // Level k shifts by 2**k; the reserved opcode falls through every level unchanged.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        localparam int STEP = 1 << k;
        logic [DATA_W-1:0] sll_v;
        logic [DATA_W-1:0] sra_v;
        logic [DATA_W-1:0] ror_v;

        assign sll_v = {lvl[k][DATA_W-1-STEP:0], {STEP{1'b0}}};
        assign sra_v = {{STEP{lvl[k][DATA_W-1]}}, lvl[k][DATA_W-1:STEP]};
        assign ror_v = {lvl[k][STEP-1:0], lvl[k][DATA_W-1:STEP]};

        assign lvl[k+1] = !shamt[k]          ? lvl[k] :
                          (opcode == OP_SLL) ? sll_v  :
                          (opcode == OP_SRA) ? sra_v  :
                          (opcode == OP_ROR) ? ror_v  : lvl[k];
    end

    assign result = lvl[SHAMT_W];

endmodule

// File: rtl/shift_ex_pipe.sv
// rtl/shift_ex_pipe.sv - two-stage shift execution slot with forwarding tap and Z flag
module shift_ex_pipe
    import shift_ex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int REG_W   = DEF_REG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [1:0]         in_opcode,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_imm,
    input  logic [REG_W-1:0]   in_rd,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_result,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_wen,
    output logic               fwd_valid,
    output logic [REG_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               z_flag,
    output logic               illegal
);

    stage_a_t          a_q;
    logic              b_valid;
    logic [1:0]        b_opcode;
    logic [DATA_W-1:0] core_result;

    shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .opcode (a_q.opcode),
        .data   (a_q.data),
        .shamt  (a_q.imm),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_valid    <= 1'b0;
            b_opcode   <= OP_SLL;
            out_result <= '0;
            out_rd     <= '0;
            z_flag     <= 1'b0;
        end else if (flush) begin
            a_q.valid <= 1'b0;
            b_valid   <= 1'b0;
        end else if (!stall) begin
            a_q <= '{valid: in_valid, opcode: in_opcode, data: in_data,
                     imm: in_imm, rd: in_rd};
            b_valid <= a_q.valid;
            // Result fields only move on a real op so an idle slot keeps the last result visible.
            if (a_q.valid) begin
                b_opcode   <= a_q.opcode;
                out_result <= core_result;
                out_rd     <= a_q.rd;
            end
            if (b_valid && b_opcode != OP_RSV) begin
                z_flag <= (out_result == '0);
            end
        end
    end

    assign out_valid = b_valid;
    assign out_wen   = b_valid && (b_opcode != OP_RSV) && (out_rd != '0);
    assign fwd_valid = out_valid && out_wen;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_result;
    assign illegal   = b_valid && (b_opcode == OP_RSV) && !stall && !flush;

endmodule

// File: tb/tb_shift_ex_pipe.sv
// tb/tb_shift_ex_pipe.sv - directed table-driven bench for shift_ex_pipe
module tb_shift_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_opcode;
    logic [15:0] in_data;
    logic [3:0]  in_imm;
    logic [3:0]  in_rd;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic        z_flag;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    shift_ex_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .z_flag     (z_flag),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [3:0]  imm;
        logic [3:0]  rd;
        logic [15:0] exp;
        logic        exp_wen;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] imm, input logic [3:0] rd);
        in_valid  = v;
        in_opcode = op;
        in_data   = d;
        in_imm    = imm;
        in_rd     = rd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " out_valid"},  32'(out_valid),  0);
        chk({tag, " out_result"}, 32'(out_result), 0);
        chk({tag, " out_rd"},     32'(out_rd),     0);
        chk({tag, " out_wen"},    32'(out_wen),    0);
        chk({tag, " fwd_valid"},  32'(fwd_valid),  0);
        chk({tag, " z_flag"},     32'(z_flag),     0);
        chk({tag, " illegal"},    32'(illegal),    0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 16'h8000, 4'd15, 4'd3,  16'hFFFF, 1'b1};
        vecs[1]  = '{2'b00, 16'h0001, 4'd15, 4'd1,  16'h8000, 1'b1};
        vecs[2]  = '{2'b10, 16'h0001, 4'd1,  4'd2,  16'h8000, 1'b1};
        vecs[3]  = '{2'b10, 16'h1234, 4'd4,  4'd4,  16'h4123, 1'b1};
        vecs[4]  = '{2'b01, 16'h7FF0, 4'd4,  4'd5,  16'h07FF, 1'b1};
        vecs[5]  = '{2'b00, 16'h8000, 4'd1,  4'd0,  16'h0000, 1'b0};
        vecs[6]  = '{2'b00, 16'h1234, 4'd0,  4'd6,  16'h1234, 1'b1};
        vecs[7]  = '{2'b01, 16'hF0F0, 4'd0,  4'd7,  16'hF0F0, 1'b1};
        vecs[8]  = '{2'b10, 16'hABCD, 4'd0,  4'd8,  16'hABCD, 1'b1};
        vecs[9]  = '{2'b01, 16'h8001, 4'd1,  4'd9,  16'hC000, 1'b1};
        vecs[10] = '{2'b10, 16'h8001, 4'd15, 4'd10, 16'h0003, 1'b1};
        vecs[11] = '{2'b00, 16'hABCD, 4'd8,  4'd11, 16'hCD00, 1'b1};

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b0;

        // Back-to-back stream: vector i issues in cycle i and is checked in cycle i+2.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].imm, vecs[i].rd);
            else        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
            tick();
            if (i >= 1) begin
                chk($sformatf("v%0d out_valid", i-1),  32'(out_valid),  1);
                chk($sformatf("v%0d out_result", i-1), 32'(out_result), 32'(vecs[i-1].exp));
                chk($sformatf("v%0d out_rd", i-1),     32'(out_rd),     32'(vecs[i-1].rd));
                chk($sformatf("v%0d out_wen", i-1),    32'(out_wen),    32'(vecs[i-1].exp_wen));
                chk($sformatf("v%0d fwd_valid", i-1),  32'(fwd_valid),  32'(vecs[i-1].exp_wen));
                chk($sformatf("v%0d fwd_data", i-1),   32'(fwd_data),   32'(vecs[i-1].exp));
                chk($sformatf("v%0d fwd_rd", i-1),     32'(fwd_rd),     32'(vecs[i-1].rd));
                chk($sformatf("v%0d illegal", i-1),    32'(illegal),    0);
            end
            if (i >= 2) begin
                chk($sformatf("v%0d z_flag", i-2), 32'(z_flag), 32'(vecs[i-2].exp == 16'h0));
            end
        end
        tick();
        chk("drain out_valid",  32'(out_valid),  0);
        chk("drain out_result", 32'(out_result), 16'hCD00);
        chk("drain out_wen",    32'(out_wen),    0);
        chk("drain z_flag",     32'(z_flag),     0);

        // Stall three cycles with the op parked in stage A.
        drive(1'b1, 2'b00, 16'h0000, 4'd0, 4'd1);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stall%0d out_valid", s), 32'(out_valid), 0);
            chk($sformatf("stall%0d z_flag", s),    32'(z_flag),    0);
        end
        stall = 1'b0;
        tick();
        chk("post-stall out_valid",  32'(out_valid),  1);
        chk("post-stall out_result", 32'(out_result), 0);
        chk("post-stall out_rd",     32'(out_rd),     1);
        chk("post-stall z_flag",     32'(z_flag),     0);
        tick();
        chk("post-stall retire z",   32'(z_flag),     1);

        // Non-zero result clears Z, then a reserved op with zero data must leave Z alone.
        drive(1'b1, 2'b00, 16'h0001, 4'd0, 4'd1);
        tick();
        drive(1'b1, 2'b11, 16'h0000, 4'd5, 4'd2);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
        tick();
        chk("rsv out_valid",  32'(out_valid),  1);
        chk("rsv illegal",    32'(illegal),    1);
        chk("rsv out_wen",    32'(out_wen),    0);
        chk("rsv fwd_valid",  32'(fwd_valid),  0);
        chk("rsv out_result", 32'(out_result), 0);
        chk("rsv z before",   32'(z_flag),     0);
        tick();
        chk("rsv illegal gone", 32'(illegal),  0);
        chk("rsv z after",      32'(z_flag),   0);

        // Flush with stall while two ops are in flight.
        drive(1'b1, 2'b00, 16'h0000, 4'd0, 4'd3);
        tick();
        drive(1'b1, 2'b11, 16'h0000, 4'd0, 4'd4);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
        chk("pre-flush out_valid", 32'(out_valid), 1);
        stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush illegal held",  32'(illegal),   0);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("flush out_valid",     32'(out_valid), 0);
        chk("flush z_flag",        32'(z_flag),    0);
        tick();
        chk("flush2 out_valid",    32'(out_valid), 0);
        chk("flush2 illegal",      32'(illegal),   0);
        chk("flush2 z_flag",       32'(z_flag),    0);

        // Reset with Z set and an op sitting in stage B.
        drive(1'b1, 2'b00, 16'h0000, 4'd0, 4'd1);
        tick();
        drive(1'b1, 2'b00, 16'h0001, 4'd3, 4'd2);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'd0, 4'd0);
        tick();
        chk("pre-rst out_valid",  32'(out_valid),  1);
        chk("pre-rst out_result", 32'(out_result), 16'h0008);
        chk("pre-rst z_flag",     32'(z_flag),     1);
        rst = 1'b1;
        tick();
        chk_idle_zero("midrst");
        rst = 1'b0;
        tick();
        chk("post-rst out_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_ex_pipe.md
Name: shift_ex_pipe

Overview:
- Two-stage pipelined shift execution slot for the 16-bit core: ID/EX operand latch, then the shift datapath, then the EX/MEM result latch.
- Executes SLL, SRA and ROR with a 4-bit immediate shift amount.
- Drives the register-file write tag, a forwarding tap and the Z flag register.
- Supports pipeline stall and flush from the hazard unit.

Parameters:
- DATA_W, 16, operand/result width.
- SHAMT_W, 4, shift-amount width; must equal log2(DATA_W).
- REG_W, 4, register-specifier width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  ID stage presents an instruction this cycle.
- in_opcode  input  2  00 SLL, 01 SRA, 10 ROR, 11 reserved.
- in_data  input  DATA_W  source operand.
- in_imm  input  SHAMT_W  shift amount.
- in_rd  input  REG_W  destination register.
- stall  input  1  hold both stages.
- flush  input  1  kill both stages.
- out_valid  output  1  EX/MEM stage holds a valid op.
- out_result  output  DATA_W  registered shift result.
- out_rd  output  REG_W  destination tag.
- out_wen  output  1  register-file write enable.
- fwd_valid  output  1  forwarding tap valid (out_valid & out_wen).
- fwd_rd  output  REG_W  forwarding tag (equals out_rd).
- fwd_data  output  DATA_W  forwarding data (equals out_result).
- z_flag  output  1  architectural Z flag.
- illegal  output  1  one-cycle pulse when a reserved opcode retires.

Behaviour:
- Reset (rst=1 at a clock edge) clears both stage valids, out_result, out_rd, out_wen, z_flag and illegal to 0. Reset overrides stall and flush. Reset mid-operation discards all in-flight ops.
- Stage A (ID/EX) captures {in_valid, in_opcode, in_data, in_imm, in_rd} each edge unless stall=1.
- Stage B (EX/MEM) captures the shift-core output computed from stage A each edge unless stall=1.
- Latency: 2 cycles from in_valid to out_valid. Throughput is 1 op per cycle.
- Shift rules:
  - SLL fills with zeros.
  - SRA fills with operand bit 15.
  - ROR rotates right by in_imm.
  - Shift amount 0 passes the operand through unchanged for all three ops.
  - All arithmetic is DATA_W bits; there is no carry or overflow output.
- Reserved opcode 11:
  - out_result = operand unchanged; out_wen=0.
  - Z is not updated.
  - illegal=1 for the single cycle the op occupies stage B with stall=0.
- out_wen = stage B valid & opcode != 11 & out_rd != 0. R0 is hardwired zero and never written.
- Z flag:
  - Updates at the edge where a valid, non-reserved op leaves stage B with stall=0.
  - z_flag <= (out_result == 0). This holds even when rd=0.
  - Otherwise z_flag holds.
- Stall: both stages hold all contents. illegal is forced to 0 while stall=1. Z is not updated.
- Flush:
  - Clears both stage valids at the next edge; data fields are don't-care.
  - An op in stage B at the flush edge does not update Z and does not pulse illegal.
- Stall and flush together: flush wins.
- Idle: out_valid=0 implies out_wen=0 and fwd_valid=0. out_result holds its last value.

Decomposition:
- Package shift_ex_pkg:
  - Opcode localparams OP_SLL=2'b00, OP_SRA=2'b01, OP_ROR=2'b10, OP_RSV=2'b11.
  - Default widths.
  - A typedef for the stage-A payload struct {valid, opcode, data, imm, rd}.
- One sub-module, shift_core: combinational 4-level log shifter selecting SLL/SRA/ROR per level. It contains no state. The pipeline registers, flag register and control stay in shift_ex_pipe.

Test Plan:
- SRA in_data=0x8000, imm=15, rd=3 at cycle 0 → cycle 2: out_valid=1, out_result=0xFFFF, out_wen=1, out_rd=3; cycle 3: z_flag=0.
- Back-to-back ops, one per cycle:
  - SLL 0x0001 imm=15 → 0x8000.
  - ROR 0x0001 imm=1 → 0x8000.
  - ROR 0x1234 imm=4 → 0x4123.
  - SRA 0x7FF0 imm=4 → 0x07FF.
  - Results appear on consecutive cycles 2..5.
- SLL 0x8000 imm=1, rd=0 → out_result=0x0000, out_wen=0, fwd_valid=0; z_flag becomes 1 one cycle later.
- Stall: issue an op, then assert stall for 3 cycles while it is in stage A → out_valid stays 0 during the stall. The result appears 1 cycle after stall drops. Z is unchanged during the stall.
- Flush with stall: assert flush with stall=1 while two ops are in flight → both are dropped, out_valid=0, no Z update, no illegal pulse.
- Reserved opcode and reset:
  - Opcode 11 with data 0x0000 → illegal pulses exactly 1 cycle, out_wen=0, z_flag unchanged.
  - rst=1 mid-stream → next cycle all outputs are 0.
